cordic_vector: RTL and testbench
================================

CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 Parameter: ITERATIONS, 16, number of micro-rotations; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  x_in/y_in valid.
REQ-005 Port: in_ready  output  1  block can accept a vector.
REQ-006 Port: x_in  input  32  signed Q16.16 x coordinate.
REQ-007 Port: y_in  input  32  signed Q16.16 y coordinate.
REQ-008 Port: out_valid  output  1  mag/angle valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: mag  output  32  unsigned Q16.16 magnitude.
REQ-011 Port: angle  output  32  signed Q16.16 radians, atan2(y,x), range [-pi, +pi].

Function
REQ-012 The block SHALL be iterative, with one micro-rotation per clock and FSM states IDLE, ITER, COMP (only when REQ-030 is enabled) and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept: in_valid&&in_ready at an edge SHALL load the pre-rotated x/y/z, clear the iteration counter and enter ITER.
REQ-015 Pre-rotation: x_in>=0 gives x=x_in, y=y_in, z=0; x_in<0 && y_in>=0 gives x=y_in, y=-x_in, z=+102944; x_in<0 && y_in<0 gives x=-y_in, y=x_in, z=-102944.
REQ-016 Datapath registers SHALL be 34-bit signed, with inputs sign-extended, so no intermediate overflows.
REQ-017 Iteration i: if y>=0 then x+=y>>>i, y-=x>>>i, z+=atan[i]; else x-=y>>>i, y+=x>>>i, z-=atan[i]; shifts arithmetic, and all updates SHALL use pre-iteration values.
REQ-018 atan[0..15] SHALL be 51471, 30385, 16054, 8149, 4090, 2047, 1023, 511, 255, 127, 63, 31, 15, 7, 3, 1, held as internal constants.
REQ-019 After iteration ITERATIONS-1 the FSM SHALL go to DONE, or to COMP when enabled.
REQ-020 Latency: out_valid SHALL rise ITERATIONS+1 edges after the accepting edge (17 at default), or ITERATIONS+2 with compensation.
REQ-021 In DONE, mag and angle SHALL stay stable while out_ready=0; on out_valid&&out_ready the FSM SHALL return to IDLE, with in_ready=1 on the next cycle.
REQ-022 mag SHALL be the final x, saturated to 0x7FFFFFFF when it exceeds 31 bits; angle SHALL be the final z truncated to 32 bits.
REQ-023 Zero vector: when x_in==0 && y_in==0 at accept, the block SHALL report mag=0 and angle=0, with the same latency.
REQ-024 in_valid in any state other than IDLE SHALL be ignored, with no queuing.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force the FSM to IDLE.
REQ-026 During reset it SHALL force in_ready=1 (after deassertion), out_valid=0, mag=0, angle=0, counter=0, and x/y/z=0.
REQ-027 Reset during ITER/COMP/DONE SHALL abort the operation; the abandoned result SHALL never be presented.
REQ-028 in_ready SHALL be 0 while rst_n=0.
REQ-029 The first accept SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-030 Macro CORDIC_VECTOR_GAIN_COMP_EN: when defined, the COMP state SHALL multiply the final x by 39797 (1/K in Q16), shift right by 16 and round-half-up, making mag approximately the true |v|; this adds 1 cycle of latency.
REQ-031 When CORDIC_VECTOR_GAIN_COMP_EN is undefined, there SHALL be no COMP state and no multiplier, and mag SHALL equal K*|v| with K≈1.64676.

Verification
REQ-032 x_in=0x00010000, y_in=0 -> out_valid at edge 17, angle 0±8, mag 107922±16 (65536±16 with COMP).
REQ-033 x_in=y_in=0x00010000 -> angle 51471±8, mag 152624±24 (92682±16 with COMP).
REQ-034 Quadrants: (-1.0,0) -> angle 205887±16; (0,-1.0) -> angle -102944±8; (-1.0,-1.0) -> angle -154415±16.
REQ-035 Zero vector (0,0) -> mag 0, angle 0, latency 17.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, then a back-to-back second vector is accepted on the next cycle.
REQ-037 Reset: assert rst_n=0 at iteration 8 -> out_valid=0 and in_ready=0 while low; after release no stale result appears and a fresh (1,0) vector produces the REQ-032 response.

Source files
------------

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring: Q16.16 (x,y) -> magnitude and atan2 angle; CORDIC_VECTOR_GAIN_COMP_EN adds 1/K scaling of mag.
// Latency: ITERATIONS+1 cycles from accept to out_valid (ITERATIONS+2 with gain compensation).
// Backpressure: one vector in flight; in_ready only when idle, result held in DONE until out_ready.
module cordic_vector #(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mag,
  output logic [31:0] angle
);

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  localparam logic signed [33:0] HALF_PI = 34'sd102944;
  localparam logic [4:0]         LAST    = 5'(ITERATIONS);

  state_t             state, state_nxt;
  logic signed [33:0] x, y, z;
  logic signed [33:0] x_nxt, y_nxt, z_nxt;
  logic signed [33:0] x_ld, y_ld, z_ld;
  logic signed [33:0] xe, ye;
  logic [4:0]         cnt;
  logic               zero;
  logic [31:0]        mag_r, angle_r;

  function automatic logic signed [33:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 34'sd51471;
      5'd1:    atan_lut = 34'sd30385;
      5'd2:    atan_lut = 34'sd16054;
      5'd3:    atan_lut = 34'sd8149;
      5'd4:    atan_lut = 34'sd4090;
      5'd5:    atan_lut = 34'sd2047;
      5'd6:    atan_lut = 34'sd1023;
      5'd7:    atan_lut = 34'sd511;
      5'd8:    atan_lut = 34'sd255;
      5'd9:    atan_lut = 34'sd127;
      5'd10:   atan_lut = 34'sd63;
      5'd11:   atan_lut = 34'sd31;
      5'd12:   atan_lut = 34'sd15;
      5'd13:   atan_lut = 34'sd7;
      5'd14:   atan_lut = 34'sd3;
      5'd15:   atan_lut = 34'sd1;
      default: atan_lut = '0;
    endcase
  endfunction

  // Magnitude is non-negative by construction; anything beyond 31 bits clamps.
  function automatic logic [31:0] sat(input logic signed [33:0] v);
    if (v[33])                 sat = '0;
    else if (v[32:31] != 2'b0) sat = 32'h7FFF_FFFF;
    else                       sat = v[31:0];
  endfunction

  always_comb begin
    xe   = {{2{x_in[31]}}, x_in};
    ye   = {{2{y_in[31]}}, y_in};
    x_ld = xe;
    y_ld = ye;
    z_ld = '0;
    if (x_in[31]) begin
      if (!y_in[31]) begin
        x_ld = ye;
        y_ld = -xe;
        z_ld = HALF_PI;
      end else begin
        x_ld = -ye;
        y_ld = xe;
        z_ld = -HALF_PI;
      end
    end
  end

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!y[33]) begin
      x_nxt = x + (y >>> cnt);
      y_nxt = y - (x >>> cnt);
      z_nxt = z + atan_lut(cnt);
    end else begin
      x_nxt = x - (y >>> cnt);
      y_nxt = y + (x >>> cnt);
      z_nxt = z - atan_lut(cnt);
    end
  end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  logic signed [50:0] prod;
  logic signed [33:0] x_comp;
  always_comb begin
    prod   = 51'(x) * 51'sd39797 + 51'sd32768;
    x_comp = 34'(prod >>> 16);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = ITER;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
      ITER: if (cnt == LAST) state_nxt = COMP;
      COMP: state_nxt = DONE;
`else
      ITER: if (cnt == LAST) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cnt     <= '0;
      zero    <= 1'b0;
      mag_r   <= '0;
      angle_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x    <= x_ld;
          y    <= y_ld;
          z    <= z_ld;
          cnt  <= '0;
          zero <= (x_in == 32'd0) && (y_in == 32'd0);
        end
        ITER: begin
          if (cnt != LAST) begin
            x   <= x_nxt;
            y   <= y_nxt;
            z   <= z_nxt;
            cnt <= cnt + 5'd1;
          end
`ifndef CORDIC_VECTOR_GAIN_COMP_EN
          else begin
            mag_r   <= sat(x);
            angle_r <= zero ? 32'd0 : 32'(z);
          end
`endif
        end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
        COMP: begin
          mag_r   <= sat(x_comp);
          angle_r <= zero ? 32'd0 : 32'(z);
        end
`endif
        default: ;
      endcase
    end
  end

  // The zero vector still rotates z through the table, so its angle is forced to 0.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign mag       = mag_r;
  assign angle     = angle_r;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed vectors for cordic_vector; expectations queued at accept, checked by a monitor on each output handshake.
module tb_cordic_vector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        in_ready, out_valid;
  logic [31:0] mag, angle;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam int LAT = 18;
  localparam int M1  = 65536;
  localparam int M11 = 92682;
  localparam int T11 = 16;
`else
  localparam int LAT = 17;
  localparam int M1  = 107922;
  localparam int M11 = 152624;
  localparam int T11 = 24;
`endif
  localparam logic [31:0] P1 = 32'h0001_0000;
  localparam logic [31:0] N1 = 32'hFFFF_0000;

  typedef struct {int mag_e; int mag_t; int ang_e; int ang_t; int acc;} exp_t;
  exp_t sb[$];

  cordic_vector #(.ITERATIONS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .angle(angle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  bit   mon_prev = 1'b0;
  int   mon_first = 0;
  exp_t mon_e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) mon_prev = 1'b0;
      else begin
        if (out_valid && !mon_prev) mon_first = cyc;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 1'b0, mag, 0);
          else begin
            mon_e = sb.pop_front();
            chk("latency", (mon_first - mon_e.acc) == LAT, mon_first - mon_e.acc, LAT);
            chk("mag", iabs(int'(mag) - mon_e.mag_e) <= mon_e.mag_t, int'(mag), mon_e.mag_e);
            chk("angle", iabs(int'($signed(angle)) - mon_e.ang_e) <= mon_e.ang_t,
                int'($signed(angle)), mon_e.ang_e);
          end
        end
        mon_prev = out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] xv, input logic [31:0] yv, input int me, input int mt,
                      input int ae, input int at, input bit push);
    bit done;
    done     = 1'b0;
    x_in     = xv;
    y_in     = yv;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 1'b0, 0, 1);
    else if (push) sb.push_back('{me, mt, ae, at, acc_cyc});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 1'b0, sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] m0, a0;
  int          hs, seen, k;
  initial begin : main
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready == 1'b0, in_ready, 0);
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_mag", mag == 32'd0, mag, 0);
    chk("rst_angle", angle == 32'd0, angle, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready == 1'b1, in_ready, 1);

    send(P1, 32'd0, M1, 16, 0, 8, 1'b1);
    send(P1, P1, M11, T11, 51471, 8, 1'b1);
    send(N1, 32'd0, M1, 32, 205887, 16, 1'b1);
    send(32'd0, N1, M1, 32, -102944, 8, 1'b1);
    send(N1, N1, M11, T11, -154415, 16, 1'b1);
    send(32'd0, 32'd0, 0, 0, 0, 0, 1'b1);
    drain();

    // Hold the result in DONE, then release and issue the next vector immediately.
    out_ready = 1'b0;
    send(P1, 32'd0, M1, 16, 0, 8, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", out_valid == 1'b1, out_valid, 1);
    m0 = mag;
    a0 = angle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", out_valid && !in_ready && mag == m0 && angle == a0, mag, m0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    hs = cyc + 1;
    send(P1, P1, M11, T11, 51471, 8, 1'b1);
    chk("back_to_back", acc_cyc == hs + 1, acc_cyc, hs + 1);
    drain();

    // Abort mid-iteration; the abandoned result must never surface.
    send(P1, 32'd0, 0, 0, 0, 0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("rst_mid_in_ready", in_ready == 1'b0, in_ready, 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_result", seen == 0, seen, 0);
    send(P1, 32'd0, M1, 16, 0, 8, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
